// File: rtl/maxterm_sweep_ctrl_if.sv
// Bundle between the maxterm sweep controller and the function units plus host control/status.
// The master side is the controller; the slave side is the units/host that feed it.
interface maxterm_sweep_ctrl_if #(
    parameter int N_VARS  = 3,
    parameter int N_FUNCS = 5
);
    localparam int FSEL_W = (N_FUNCS > 1) ? $clog2(N_FUNCS) : 1;
    localparam int CNT_W  = $clog2(N_FUNCS * (2 ** N_VARS) + 1);

    logic                start;
    logic                hold;
    logic [N_VARS-1:0]   vec;
    logic [FSEL_W-1:0]   fsel;
    logic [N_FUNCS-1:0]  s_in;
    logic [N_FUNCS-1:0]  c_in;
    logic                busy;
    logic                done;
    logic                pass;
    logic [CNT_W-1:0]    mismatch_cnt;
    logic [N_FUNCS-1:0]  func_fail;
    logic                fail_valid;
    logic [FSEL_W-1:0]   fail_func;
    logic [N_VARS-1:0]   fail_idx;

    modport master (
        input  start, hold, s_in, c_in,
        output vec, fsel, busy, done, pass, mismatch_cnt,
               func_fail, fail_valid, fail_func, fail_idx
    );

    modport slave (
        output start, hold, s_in, c_in,
        input  vec, fsel, busy, done, pass, mismatch_cnt,
               func_fail, fail_valid, fail_func, fail_idx
    );
endinterface

// File: rtl/maxterm_sweep_ctrl.sv
// Sweeps every input combination across N_FUNCS shared function units, comparing reduced (s)
// against control (c) outputs and accumulating mismatch count, per-unit fail mask and first failure.
module maxterm_sweep_ctrl #(
    parameter int N_VARS  = 3,
    parameter int N_FUNCS = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    maxterm_sweep_ctrl_if.master    bus
);
    localparam int FSEL_W = (N_FUNCS > 1) ? $clog2(N_FUNCS) : 1;
    localparam int CNT_W  = $clog2(N_FUNCS * (2 ** N_VARS) + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [N_VARS-1:0] VEC_LAST  = '1;
    localparam logic [FSEL_W-1:0] FSEL_LAST = FSEL_W'(N_FUNCS - 1);

    logic [1:0]         state_q, state_d;
    logic [N_VARS-1:0]  vec_q, vec_d;
    logic [FSEL_W-1:0]  fsel_q, fsel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_FUNCS-1:0] func_fail_q, func_fail_d;
    logic               fail_valid_q, fail_valid_d;
    logic [FSEL_W-1:0]  fail_func_q, fail_func_d;
    logic [N_VARS-1:0]  fail_idx_q, fail_idx_d;
    logic               pass_q, pass_d;
    logic               mis;

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        fsel_d       = fsel_q;
        cnt_d        = cnt_q;
        func_fail_d  = func_fail_q;
        fail_valid_d = fail_valid_q;
        fail_func_d  = fail_func_q;
        fail_idx_d   = fail_idx_q;
        pass_d       = pass_q;
        mis          = bus.s_in[fsel_q] ^ bus.c_in[fsel_q];

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d      = ST_SWEEP;
                    vec_d        = '0;
                    fsel_d       = '0;
                    cnt_d        = '0;
                    func_fail_d  = '0;
                    fail_valid_d = 1'b0;
                    fail_func_d  = '0;
                    fail_idx_d   = '0;
                    pass_d       = 1'b0;
                end
            end

            ST_SWEEP: begin
                if (!bus.hold) begin
                    if (mis) begin
                        cnt_d               = cnt_q + CNT_W'(1);
                        func_fail_d[fsel_q] = 1'b1;
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            fail_func_d  = fsel_q;
                            fail_idx_d   = vec_q;
                        end
                    end
                    // The last vector of the last unit ends the sweep; pass reflects this final compare.
                    if (vec_q == VEC_LAST) begin
                        vec_d = '0;
                        if (fsel_q == FSEL_LAST) begin
                            fsel_d  = '0;
                            state_d = ST_DONE;
                            pass_d  = (cnt_d == '0);
                        end else begin
                            fsel_d = fsel_q + FSEL_W'(1);
                        end
                    end else begin
                        vec_d = vec_q + N_VARS'(1);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            fsel_q       <= '0;
            cnt_q        <= '0;
            func_fail_q  <= '0;
            fail_valid_q <= 1'b0;
            fail_func_q  <= '0;
            fail_idx_q   <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            fsel_q       <= fsel_d;
            cnt_q        <= cnt_d;
            func_fail_q  <= func_fail_d;
            fail_valid_q <= fail_valid_d;
            fail_func_q  <= fail_func_d;
            fail_idx_q   <= fail_idx_d;
            pass_q       <= pass_d;
        end
    end

    assign bus.vec          = vec_q;
    assign bus.fsel         = fsel_q;
    assign bus.busy         = (state_q == ST_SWEEP);
    assign bus.done         = (state_q == ST_DONE);
    assign bus.pass         = pass_q;
    assign bus.mismatch_cnt = cnt_q;
    assign bus.func_fail    = func_fail_q;
    assign bus.fail_valid   = fail_valid_q;
    assign bus.fail_func    = fail_func_q;
    assign bus.fail_idx     = fail_idx_q;
endmodule

// File: tb/tb_maxterm_sweep_ctrl.sv
// Bench for maxterm_sweep_ctrl: truth-table function units with injectable faults, a step-count
// reference model compared every cycle, and end-of-sweep totals computed directly from the fault tables.
module tb_maxterm_sweep_ctrl;
    localparam int NV         = 3;
    localparam int NF         = 5;
    localparam int NCOMB      = 1 << NV;
    localparam int STEPS      = NF * NCOMB;
    localparam int FSEL_W     = (NF > 1) ? $clog2(NF) : 1;
    localparam int CNT_W      = $clog2(STEPS + 1);
    localparam int W          = 2 * NV + 2 * FSEL_W + CNT_W + NF + 4;
    localparam int WAIT_LIMIT = 400;

    logic clock;
    logic reset;

    maxterm_sweep_ctrl_if #(.N_VARS(NV), .N_FUNCS(NF)) bus ();

    maxterm_sweep_ctrl #(.N_VARS(NV), .N_FUNCS(NF)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Function units: control output is a truth table, reduced output is control xor a fault table.
    logic [NCOMB-1:0] ctrl_tt  [NF];
    logic [NCOMB-1:0] fault_tt [NF];
    logic [NF-1:0]    s_bits, c_bits;

    always_comb begin
        s_bits = '0;
        c_bits = '0;
        for (int k = 0; k < NF; k++) begin
            c_bits[k] = ctrl_tt[k][bus.vec];
            s_bits[k] = ctrl_tt[k][bus.vec] ^ fault_tt[k][bus.vec];
        end
    end

    assign bus.s_in = s_bits;
    assign bus.c_in = c_bits;

    int n_checks = 0;
    int n_errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    logic [W-1:0] dut_word;
    assign dut_word = {bus.vec, bus.fsel, bus.busy, bus.done, bus.pass, bus.mismatch_cnt,
                       bus.func_fail, bus.fail_valid, bus.fail_func, bus.fail_idx};

    // Reference model: a sweep is just step 0..STEPS-1, with unit = step / NCOMB and vector = step % NCOMB.
    int            m_mode = 0;
    int            m_step = 0;
    int            m_cnt  = 0;
    logic [NF-1:0] m_ff   = '0;
    logic          m_fv   = 1'b0;
    logic          m_pass = 1'b0;
    int            m_ffunc = 0;
    int            m_fidx  = 0;
    int            busy_run = 0;
    int            last_busy_len = 0;
    logic [W-1:0]  exp_word;

    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                m_mode = 0; m_step = 0; m_cnt = 0; m_ff = '0;
                m_fv = 1'b0; m_pass = 1'b0; m_ffunc = 0; m_fidx = 0;
            end else begin
                case (m_mode)
                    0: if (bus.start) begin
                        m_mode = 1; m_step = 0; m_cnt = 0; m_ff = '0;
                        m_fv = 1'b0; m_pass = 1'b0; m_ffunc = 0; m_fidx = 0;
                    end
                    1: if (!bus.hold) begin
                        if (fault_tt[m_step / NCOMB][m_step % NCOMB]) begin
                            m_cnt++;
                            m_ff[m_step / NCOMB] = 1'b1;
                            if (!m_fv) begin
                                m_fv = 1'b1;
                                m_ffunc = m_step / NCOMB;
                                m_fidx = m_step % NCOMB;
                            end
                        end
                        m_step++;
                        if (m_step == STEPS) begin
                            m_step = 0;
                            m_mode = 2;
                            m_pass = (m_cnt == 0);
                        end
                    end
                    default: m_mode = 0;
                endcase
            end
            #1;
            exp_word = {NV'(m_step % NCOMB), FSEL_W'(m_step / NCOMB), (m_mode == 1), (m_mode == 2),
                        m_pass, CNT_W'(m_cnt), m_ff, m_fv, FSEL_W'(m_ffunc), NV'(m_fidx)};
            checkOutput("cycle_outputs", 64'(dut_word), 64'(exp_word));
            if (reset) busy_run = 0;
            else if (bus.busy) busy_run++;
            if (bus.done) begin
                last_busy_len = busy_run;
                busy_run = 0;
            end
        end
    end

    task automatic applyStimulus(input logic st, input logic hd);
        @(negedge clock);
        bus.start = st;
        bus.hold  = hd;
    endtask

    task automatic start_sweep();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic wait_done(input int hold_pct);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < WAIT_LIMIT) begin
            applyStimulus(1'b0, ($urandom_range(0, 99) < hold_pct));
            n++;
        end
        if (bus.done !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL wait_done: done not seen within %0d cycles", WAIT_LIMIT);
        end
    endtask

    // End-of-sweep totals straight from the fault tables: count, mask, first fault in unit-major order.
    task automatic check_totals(input string name);
        int            cnt, ffunc, fidx;
        logic [NF-1:0] ff;
        logic          fv;
        cnt = 0; ff = '0; fv = 1'b0; ffunc = 0; fidx = 0;
        for (int k = 0; k < NF; k++)
            for (int v = 0; v < NCOMB; v++)
                if (fault_tt[k][v]) begin
                    cnt++;
                    ff[k] = 1'b1;
                    if (!fv) begin fv = 1'b1; ffunc = k; fidx = v; end
                end
        checkOutput({name, "_cnt"},   64'(bus.mismatch_cnt), 64'(cnt));
        checkOutput({name, "_ff"},    64'(bus.func_fail),    64'(ff));
        checkOutput({name, "_fv"},    64'(bus.fail_valid),   64'(fv));
        checkOutput({name, "_ffunc"}, 64'(bus.fail_func),    64'(fv ? ffunc : 0));
        checkOutput({name, "_fidx"},  64'(bus.fail_idx),     64'(fv ? fidx : 0));
        checkOutput({name, "_pass"},  64'(bus.pass),         64'(cnt == 0));
    endtask

    task automatic set_tables(input int fault_mode);
        for (int k = 0; k < NF; k++) begin
            ctrl_tt[k]  = NCOMB'($urandom);
            fault_tt[k] = (fault_mode == 0) ? '0 : NCOMB'($urandom & $urandom & $urandom);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        set_tables(0);
        repeat (3) @(negedge clock);
        checkOutput("reset_state", 64'(dut_word), 64'(0));
        reset = 1'b0;

        // All units correct.
        start_sweep();
        wait_done(0);
        checkOutput("t1_busy_len", 64'(last_busy_len), 64'd40);
        checkOutput("t1_pass", 64'(bus.pass), 64'd1);
        checkOutput("t1_cnt", 64'(bus.mismatch_cnt), 64'd0);
        checkOutput("t1_fv", 64'(bus.fail_valid), 64'd0);
        check_totals("t1");
        applyStimulus(1'b0, 1'b0);

        // Unit 2 wrong only at vector 5.
        set_tables(0);
        fault_tt[2] = 8'b0010_0000;
        start_sweep();
        wait_done(0);
        checkOutput("t2_cnt", 64'(bus.mismatch_cnt), 64'd1);
        checkOutput("t2_ff", 64'(bus.func_fail), 64'b00100);
        checkOutput("t2_ffunc", 64'(bus.fail_func), 64'd2);
        checkOutput("t2_fidx", 64'(bus.fail_idx), 64'd5);
        checkOutput("t2_pass", 64'(bus.pass), 64'd0);
        applyStimulus(1'b0, 1'b0);

        // Unit 0 always wrong, unit 4 wrong at vector 7.
        set_tables(0);
        fault_tt[0] = 8'hFF;
        fault_tt[4] = 8'h80;
        start_sweep();
        wait_done(0);
        checkOutput("t3_cnt", 64'(bus.mismatch_cnt), 64'd9);
        checkOutput("t3_ff", 64'(bus.func_fail), 64'b10001);
        checkOutput("t3_ffunc", 64'(bus.fail_func), 64'd0);
        checkOutput("t3_fidx", 64'(bus.fail_idx), 64'd0);
        checkOutput("t3_pass", 64'(bus.pass), 64'd0);
        applyStimulus(1'b0, 1'b0);

        // Hold for 10 cycles at unit 1, vector 3.
        set_tables(1);
        start_sweep();
        repeat (10) applyStimulus(1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b1);
        checkOutput("t4_vec_frozen", 64'(bus.vec), 64'd3);
        checkOutput("t4_fsel_frozen", 64'(bus.fsel), 64'd1);
        applyStimulus(1'b0, 1'b0);
        wait_done(0);
        checkOutput("t4_busy_len", 64'(last_busy_len), 64'd50);
        check_totals("t4");
        applyStimulus(1'b0, 1'b0);

        // Reset in the middle of a sweep, then a clean full sweep.
        start_sweep();
        repeat (16) applyStimulus(1'b0, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("t5_reset_outputs", 64'(dut_word), 64'(0));
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("t5_idle_after_reset", 64'(bus.busy), 64'd0);
        start_sweep();
        wait_done(0);
        checkOutput("t5_busy_len", 64'(last_busy_len), 64'd40);
        check_totals("t5");
        applyStimulus(1'b0, 1'b0);

        // Start re-pulsed during the sweep and in DONE.
        set_tables(1);
        start_sweep();
        repeat (5) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        wait_done(0);
        bus.start = 1'b1;
        checkOutput("t6_busy_len", 64'(last_busy_len), 64'd40);
        check_totals("t6");
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t6_idle_after_done_start", 64'(bus.busy), 64'd0);

        // Randomised sweeps with random hold, including hold toggling while idle.
        for (int r = 0; r < 8; r++) begin
            set_tables(r % 3);
            repeat (3) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
            start_sweep();
            wait_done(30);
            check_totals("rand");
            applyStimulus(1'b0, 1'b0);
        end

        repeat (2) applyStimulus(1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
